// File: rtl/multi_axis_stepper_if.sv
// Command/status bundle between the motion-register block (master) and the
// N-axis step/direction generator (slave). Vectors are packed per axis.
interface multi_axis_stepper_if #(
  parameter int NUM_AXES = 2,
  parameter int POS_W    = 32,
  parameter int DIV_W    = 20
);
  logic [NUM_AXES-1:0]       cmd_valid;
  logic [NUM_AXES-1:0]       cmd_ready;
  logic [NUM_AXES*POS_W-1:0] cmd_target;
  logic [NUM_AXES*DIV_W-1:0] cmd_period;
  logic [NUM_AXES-1:0]       abort;
  logic                      zero_pos;
  logic [NUM_AXES-1:0]       step_out;
  logic [NUM_AXES-1:0]       dir_out;
  logic [NUM_AXES*POS_W-1:0] position;
  logic [NUM_AXES-1:0]       busy;
  logic [NUM_AXES-1:0]       done;

  modport master (
    output cmd_valid, cmd_target, cmd_period, abort, zero_pos,
    input  cmd_ready, step_out, dir_out, position, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_target, cmd_period, abort, zero_pos,
    output cmd_ready, step_out, dir_out, position, busy, done
  );
endinterface

// File: rtl/multi_axis_stepper.sv
// N independent step/direction generators: each axis walks its position to an
// absolute signed target, one step per (clamped) period, with a fixed-width high pulse.
module multi_axis_stepper #(
  parameter int NUM_AXES     = 2,
  parameter int POS_W        = 32,
  parameter int DIV_W        = 20,
  parameter int PULSE_CYCLES = 100
) (
  input logic                 clock,
  input logic                 reset,
  multi_axis_stepper_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } state_t;

  localparam logic [DIV_W-1:0] MIN_PERIOD = DIV_W'(2 * PULSE_CYCLES);
  localparam logic [DIV_W-1:0] HIGH_LAST  = DIV_W'(PULSE_CYCLES - 1);
  localparam logic [DIV_W-1:0] LOW_TRIM   = DIV_W'(PULSE_CYCLES + 1);
  localparam logic [DIV_W-1:0] CNT_ONE    = DIV_W'(1);
  localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_AXES; gi++) begin : g_axis
      state_t                  state_q, state_d;
      logic signed [POS_W-1:0] pos_q, pos_d;
      logic signed [POS_W-1:0] target_q, target_d;
      logic [DIV_W-1:0]        period_q, period_d;
      logic [DIV_W-1:0]        cnt_q, cnt_d;
      logic                    dir_q, dir_d;
      logic                    step_q, step_d;
      logic                    done_q, done_d;
      logic                    abort_q, abort_d;
      logic signed [POS_W-1:0] pos_base;
      logic signed [POS_W-1:0] cmd_target;
      logic [DIV_W-1:0]        cmd_period;

      assign cmd_target = bus.cmd_target[gi*POS_W +: POS_W];
      assign cmd_period = bus.cmd_period[gi*DIV_W +: DIV_W];

      always_ff @(posedge clock) begin
        if (reset) begin
          state_q  <= ST_IDLE;
          pos_q    <= '0;
          target_q <= '0;
          period_q <= '0;
          cnt_q    <= '0;
          dir_q    <= 1'b0;
          step_q   <= 1'b0;
          done_q   <= 1'b0;
          abort_q  <= 1'b0;
        end else begin
          state_q  <= state_d;
          pos_q    <= pos_d;
          target_q <= target_d;
          period_q <= period_d;
          cnt_q    <= cnt_d;
          dir_q    <= dir_d;
          step_q   <= step_d;
          done_q   <= done_d;
          abort_q  <= abort_d;
        end
      end

      always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        target_d = target_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        done_d   = 1'b0;
        abort_d  = abort_q;
        pos_base = pos_q;

        unique case (state_q)
          ST_IDLE: begin
            abort_d = 1'b0;
            // A zero request in the accept cycle lands first, so direction is judged against 0.
            if (bus.zero_pos) pos_base = '0;
            pos_d = pos_base;
            if (bus.cmd_valid[gi]) begin
              target_d = cmd_target;
              period_d = (cmd_period < MIN_PERIOD) ? MIN_PERIOD : cmd_period;
              if ((cmd_period == '0) || (cmd_target == pos_base)) begin
                done_d = 1'b1;
              end else begin
                dir_d   = (cmd_target < pos_base);
                state_d = ST_SETUP;
              end
            end
          end

          ST_SETUP: begin
            if (bus.abort[gi]) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_HIGH;
              cnt_d   = HIGH_LAST;
              pos_d   = dir_q ? (pos_q - POS_ONE) : (pos_q + POS_ONE);
            end
          end

          ST_HIGH: begin
            abort_d = abort_q | bus.abort[gi];
            if (cnt_q == '0) begin
              state_d = ST_LOW;
              cnt_d   = period_q - LOW_TRIM;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end

          ST_LOW: begin
            abort_d = abort_q | bus.abort[gi];
            if (cnt_q == '0) begin
              if ((pos_q == target_q) || abort_d) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end else begin
                // Position moves on the edge that raises the pulse, keeping it in step with the pins.
                state_d = ST_HIGH;
                cnt_d   = HIGH_LAST;
                pos_d   = dir_q ? (pos_q - POS_ONE) : (pos_q + POS_ONE);
              end
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end

          default: state_d = ST_IDLE;
        endcase

        step_d = (state_d == ST_HIGH);
      end

      assign bus.step_out[gi]                 = step_q;
      assign bus.dir_out[gi]                  = dir_q;
      assign bus.position[gi*POS_W +: POS_W]  = pos_q;
      assign bus.busy[gi]                     = (state_q != ST_IDLE);
      assign bus.cmd_ready[gi]                = (state_q == ST_IDLE);
      assign bus.done[gi]                     = done_q;
    end
  endgenerate

endmodule

// File: tb/tb_multi_axis_stepper.sv
// Directed test-plan sequence with hand-derived checkpoints, then random traffic,
// all compared every cycle against a schedule-based model of each axis.
module tb_multi_axis_stepper;

  localparam int NA = 2;
  localparam int PW = 32;
  localparam int DW = 20;
  localparam int P  = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  multi_axis_stepper_if #(.NUM_AXES(NA), .POS_W(PW), .DIV_W(DW)) bus ();

  multi_axis_stepper #(
    .NUM_AXES(NA), .POS_W(PW), .DIV_W(DW), .PULSE_CYCLES(P)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int   t;
    int   ax;
    logic step;
    logic dir;
    int   pos;
    logic busy;
    logic done;
  } chk_t;

  chk_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   t = 0;

  // stimulus for the current cycle
  logic [NA-1:0]  in_valid, in_abort;
  logic           in_zero, in_rst;
  int             in_tgt [NA];
  int             in_per [NA];

  // per-axis move schedule: accepted in cycle c from pos0, n steps spaced eff apart
  logic m_act [NA];
  int   m_c [NA], m_pos0 [NA], m_n [NA], m_eff [NA], m_sgn [NA], m_done [NA];
  int   m_pidle [NA];
  logic m_dir [NA];

  task automatic add_chk(input int tt, input int ax, input logic s, input logic d,
                         input int p, input logic b, input logic dn);
    chk_t c;
    c.t = tt; c.ax = ax; c.step = s; c.dir = d; c.pos = p; c.busy = b; c.done = dn;
    tbl.push_back(c);
  endtask

  task automatic compare(input string tag, input int a, input logic e_step, input logic e_dir,
                         input int e_pos, input logic e_busy, input logic e_done);
    logic g_step, g_dir, g_busy, g_done, g_ready;
    int   g_pos;
    g_step  = bus.step_out[a];
    g_dir   = bus.dir_out[a];
    g_busy  = bus.busy[a];
    g_done  = bus.done[a];
    g_ready = bus.cmd_ready[a];
    g_pos   = $signed(bus.position[a*PW +: PW]);
    n_vec++;
    if (g_step !== e_step || g_dir !== e_dir || g_pos != e_pos || g_busy !== e_busy ||
        g_done !== e_done || g_ready !== !e_busy) begin
      n_bad++;
      $display("FAIL %s t=%0d axis%0d got step=%0b dir=%0b pos=%0d busy=%0b done=%0b ready=%0b required step=%0b dir=%0b pos=%0d busy=%0b done=%0b ready=%0b",
               tag, t, a, g_step, g_dir, g_pos, g_busy, g_done, g_ready,
               e_step, e_dir, e_pos, e_busy, e_done, !e_busy);
    end
  endtask

  task automatic check_cycle();
    for (int a = 0; a < NA; a++) begin
      logic e_step, e_busy, e_done;
      int   e_pos, k, rel;
      e_step = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_pos = m_pidle[a];
      if (m_act[a]) begin
        k = 0;
        if (t >= m_c[a] + 2 && m_n[a] > 0) begin
          rel = t - m_c[a] - 2;
          k = rel / m_eff[a] + 1;
          if (k > m_n[a]) k = m_n[a];
          e_step = (rel / m_eff[a] < m_n[a]) && (rel % m_eff[a] < P);
        end
        e_pos  = m_pos0[a] + m_sgn[a] * k;
        e_busy = (t >= m_c[a] + 1) && (t < m_done[a]);
        e_done = (t == m_done[a]);
      end
      compare("model", a, e_step, m_dir[a], e_pos, e_busy, e_done);
    end
    foreach (tbl[i]) begin
      if (tbl[i].t == t)
        compare("plan", tbl[i].ax, tbl[i].step, tbl[i].dir, tbl[i].pos, tbl[i].busy, tbl[i].done);
    end
    for (int a = 0; a < NA; a++) begin
      if (m_act[a] && t >= m_done[a]) begin
        m_pidle[a] = m_pos0[a] + m_sgn[a] * m_n[a];
        m_act[a]   = 1'b0;
      end
    end
  endtask

  task automatic clear_inputs();
    in_valid = '0; in_abort = '0; in_zero = 1'b0; in_rst = 1'b0;
    for (int a = 0; a < NA; a++) begin
      in_tgt[a] = 0; in_per[a] = 0;
    end
  endtask

  task automatic cmd(input int a, input int tgt, input int per);
    in_valid[a] = 1'b1; in_tgt[a] = tgt; in_per[a] = per;
  endtask

  task automatic apply_and_advance();
    int base, eff, k;
    bus.cmd_valid = in_valid;
    bus.abort     = in_abort;
    bus.zero_pos  = in_zero;
    reset         = in_rst;
    for (int a = 0; a < NA; a++) begin
      bus.cmd_target[a*PW +: PW] = in_tgt[a];
      bus.cmd_period[a*DW +: DW] = DW'(in_per[a]);
    end
    if (in_rst) begin
      for (int a = 0; a < NA; a++) begin
        m_act[a] = 1'b0; m_pidle[a] = 0; m_dir[a] = 1'b0;
      end
    end else begin
      for (int a = 0; a < NA; a++) begin
        if (in_abort[a] && m_act[a] && t >= m_c[a] + 1 && t < m_done[a]) begin
          if (t == m_c[a] + 1) begin
            m_n[a] = 0; m_done[a] = m_c[a] + 2;
          end else begin
            k = (t - m_c[a] - 2) / m_eff[a] + 1;
            if (k < m_n[a]) m_n[a] = k;
            m_done[a] = m_c[a] + 2 + m_n[a] * m_eff[a];
          end
        end
      end
      if (in_zero)
        for (int a = 0; a < NA; a++) if (!m_act[a]) m_pidle[a] = 0;
      for (int a = 0; a < NA; a++) begin
        if (in_valid[a] && !m_act[a]) begin
          base = m_pidle[a];
          eff  = (in_per[a] < 2 * P) ? 2 * P : in_per[a];
          m_act[a] = 1'b1; m_c[a] = t; m_pos0[a] = base; m_eff[a] = eff; m_sgn[a] = 1;
          if (in_per[a] == 0 || in_tgt[a] == base) begin
            m_n[a] = 0; m_done[a] = t + 1;
          end else begin
            m_n[a]    = (in_tgt[a] > base) ? in_tgt[a] - base : base - in_tgt[a];
            m_sgn[a]  = (in_tgt[a] < base) ? -1 : 1;
            m_dir[a]  = (in_tgt[a] < base);
            m_done[a] = t + 2 + m_n[a] * eff;
          end
        end
      end
    end
    @(negedge clock);
    t++;
  endtask

  initial begin
    // hand-derived checkpoints: t, axis, step, dir, pos, busy, done
    add_chk(0, 0, 0, 0, 0, 0, 0);   add_chk(0, 1, 0, 0, 0, 0, 0);
    add_chk(3, 0, 0, 0, 0, 1, 0);   add_chk(4, 0, 1, 0, 1, 1, 0);
    add_chk(7, 0, 1, 0, 1, 1, 0);   add_chk(8, 0, 0, 0, 1, 1, 0);
    add_chk(14, 0, 1, 0, 2, 1, 0);  add_chk(24, 0, 1, 0, 3, 1, 0);
    add_chk(33, 0, 0, 0, 3, 1, 0);  add_chk(34, 0, 0, 0, 3, 0, 1);
    add_chk(35, 0, 0, 0, 3, 0, 0);
    add_chk(43, 1, 0, 1, 0, 1, 0);  add_chk(44, 1, 1, 1, -1, 1, 0);
    add_chk(47, 1, 1, 1, -1, 1, 0); add_chk(48, 1, 0, 1, -1, 1, 0);
    add_chk(52, 1, 1, 1, -2, 1, 0); add_chk(52, 0, 0, 0, 3, 0, 0);
    add_chk(60, 1, 0, 1, -2, 0, 1);
    add_chk(71, 1, 0, 0, -2, 1, 0); add_chk(81, 0, 1, 0, 5, 1, 0);
    add_chk(81, 1, 0, 0, -1, 1, 0); add_chk(84, 1, 1, 0, 0, 1, 0);
    add_chk(84, 0, 1, 0, 5, 1, 0);  add_chk(85, 0, 0, 0, 5, 1, 0);
    add_chk(90, 0, 0, 0, 5, 0, 1);  add_chk(90, 1, 0, 0, 0, 1, 0);
    add_chk(96, 1, 0, 0, 0, 0, 1);
    add_chk(114, 0, 1, 0, 6, 1, 0); add_chk(122, 0, 1, 0, 7, 1, 0);
    add_chk(125, 0, 1, 0, 7, 1, 0); add_chk(126, 0, 0, 0, 7, 1, 0);
    add_chk(131, 0, 0, 0, 7, 1, 0); add_chk(132, 0, 0, 0, 7, 0, 1);
    add_chk(134, 0, 0, 0, 7, 0, 0);
    add_chk(141, 0, 0, 0, 7, 0, 1); add_chk(142, 0, 0, 0, 7, 0, 0);
    add_chk(146, 1, 0, 0, 0, 0, 1); add_chk(147, 1, 0, 0, 0, 0, 0);
    add_chk(168, 1, 0, 1, -2, 0, 1);
    add_chk(175, 0, 1, 0, 8, 1, 0); add_chk(176, 0, 0, 0, 8, 1, 0);
    add_chk(176, 1, 0, 1, 0, 0, 0); add_chk(182, 0, 1, 0, 9, 1, 0);
    add_chk(183, 0, 0, 0, 0, 0, 0); add_chk(183, 1, 0, 0, 0, 0, 0);

    for (int a = 0; a < NA; a++) begin
      m_act[a] = 1'b0; m_c[a] = 0; m_pos0[a] = 0; m_n[a] = 0; m_eff[a] = 2 * P;
      m_sgn[a] = 1; m_done[a] = 0; m_pidle[a] = 0; m_dir[a] = 1'b0;
    end
    clear_inputs();
    bus.cmd_valid = '0; bus.abort = '0; bus.zero_pos = 1'b0;
    bus.cmd_target = '0; bus.cmd_period = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    t = 0;

    // directed test-plan sequence
    while (t < 190) begin
      check_cycle();
      clear_inputs();
      case (t)
        2:   cmd(0, 3, 10);
        10:  cmd(0, -50, 10);            // busy: must be dropped
        42:  cmd(1, -2, 3);
        70:  begin cmd(0, 5, 9); cmd(1, 0, 12); end
        110: cmd(0, 10, 10);
        123: in_abort[0] = 1'b1;
        140: cmd(0, 7, 10);
        145: cmd(1, 5, 0);
        150: cmd(1, -2, 8);
        170: cmd(0, 20, 8);
        175: in_zero = 1'b1;
        182: in_rst = 1'b1;
        default: ;
      endcase
      apply_and_advance();
    end

    // random traffic
    repeat (3000) begin
      check_cycle();
      clear_inputs();
      for (int a = 0; a < NA; a++) begin
        if ($urandom_range(0, 5) == 0)
          cmd(a, m_pidle[a] + int'($urandom_range(0, 10)) - 5, int'($urandom_range(0, 14)));
        if ($urandom_range(0, 39) == 0) in_abort[a] = 1'b1;
      end
      if ($urandom_range(0, 29) == 0) in_zero = 1'b1;
      if ($urandom_range(0, 1499) == 0) in_rst = 1'b1;
      apply_and_advance();
    end
    check_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_axis_stepper.md
Name: multi_axis_stepper

Overview:
Parametrised N-axis step/direction motion generator, successor to the fixed two-axis button/register-driven stepper and free-running position counters in the top-level wrapper. Each axis accepts an absolute signed target position and a step period, emits rate-controlled step pulses with properly set-up direction, and tracks position exactly as steps are issued. It sits between the processor's memory-mapped motion registers and the motor driver pins, and replaces the per-clock x/y position registers.

Parameters:
NUM_AXES, 2, number of independent axes
POS_W, 32, signed position/target width
DIV_W, 20, step period counter width, in clock cycles
PULSE_CYCLES, 100, step high time in clocks; minimum effective period is 2*PULSE_CYCLES

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
cmd_valid  in  NUM_AXES  per-axis move request
cmd_ready  out  NUM_AXES  per-axis; high when axis is IDLE
cmd_target  in  NUM_AXES*POS_W  packed signed absolute targets; axis i at [i*POS_W +: POS_W]
cmd_period  in  NUM_AXES*DIV_W  packed step periods in clocks
abort  in  NUM_AXES  per-axis stop request
zero_pos  in  1  clear position of all IDLE axes
step_out  out  NUM_AXES  step pulses to driver
dir_out  out  NUM_AXES  1 = decrementing (left/up), 0 = incrementing
position  out  NUM_AXES*POS_W  packed signed current positions
busy  out  NUM_AXES  high when state != IDLE
done  out  NUM_AXES  one-cycle pulse at move completion or abort

Behaviour:
- Reset: all axes IDLE; step_out=0, dir_out=0, position=0, busy=0, done=0, cmd_ready=1. Reset mid-pulse drops step_out on the next edge.
- Per-axis FSM: IDLE, SETUP, HIGH, LOW. Axes are fully independent.
- Accept: cmd_valid & cmd_ready on a clock edge latches target and eff_period = max(cmd_period, 2*PULSE_CYCLES). cmd_valid while busy is ignored, with no queuing.
- cmd_period = 0: the command is accepted and completes as abort, with no steps and done pulsed next cycle.
- IDLE -> SETUP (1 cycle): dir_out = (target < position), signed compare. If target == position, go directly to IDLE with done pulse, with no SETUP and no step. That done comes 1 cycle after accept.
- SETUP -> HIGH: step_out=1 for exactly PULSE_CYCLES cycles. position is updated by ±1 on the edge entering HIGH, so it shows the new value in the first cycle step_out is high.
- HIGH -> LOW: step_out=0 for eff_period - PULSE_CYCLES cycles.
- End of LOW:
  - if position == target or abort is latched: IDLE, done=1 for that first IDLE cycle, cmd_ready=1 same cycle.
  - else: HIGH again; dir_out is unchanged.
- Rising-edge-to-rising-edge step spacing equals eff_period exactly.
- dir_out changes only in SETUP and is stable at least 1 cycle before and throughout every step pulse.
- abort: sampled in any state and held in a sticky per-axis flag.
  - In IDLE it is ignored.
  - In SETUP it goes to IDLE with done and no step.
  - In HIGH/LOW the current pulse and its LOW phase complete; no truncated pulse; the position stays consistent with emitted steps.
- zero_pos: clears position only for axes in IDLE that cycle. Busy axes are unaffected.
- cmd_valid and zero_pos in the same cycle on an IDLE axis: zero applies first, and direction is computed against 0.
- Arithmetic: position is two's complement POS_W. Motion is always toward target, so it never wraps within the legal signed range. Period counters are DIV_W-bit unsigned; cmd_period values ≥ 2^DIV_W are not representable.
- Latency: accept → first step_out high = 2 cycles.

Test Plan:
- PULSE_CYCLES=4, axis0 target=+3, period=10 from pos 0 → dir_out=0; step rises at cycles 2, 12, 22; each pulse is 4 high; position 1, 2, 3; done at cycle 32; cmd_ready=1 at cycle 32.
- axis1 target=-2, period=3 (clamped to 8) → dir_out=1 set at SETUP; steps 8 cycles apart; position -1, -2; axis0 idle throughout.
- Both axes commanded in the same cycle, different periods → independent step trains; each done is independent; no cross-talk on position.
- Abort asserted mid-HIGH of the 2nd of 5 steps → pulse completes at full 4 cycles; position=2; done after LOW; no further steps.
- target == position (0), and separately period=0 → no step_out; done 1 cycle after accept.
- zero_pos while axis0 busy and axis1 idle at -2 → axis1=0 and axis0 unchanged. Then reset asserted mid-move → step_out=0, position=0, busy=0 next cycle.
